bus_arbit_rr: RTL and testbench
===============================

# bus_arbit_rr

Two-master round-robin bus arbiter with a bounded hold time. It replaces the fixed-behaviour arbiter in front of the shared bus: it takes `m0_req`/`m1_req` and produces the `m0_grant`/`m1_grant` pair that drives the bus master-select muxes. While the bus is contested, no master can hold it for more than MAX_HOLD consecutive cycles. Grants are registered (Moore), one-hot or zero, and never both high.

## Interface
- MAX_HOLD, 8: maximum consecutive grant cycles for one master while the other is requesting; legal range 2..256.
- CW, $clog2(MAX_HOLD): hold counter width; derived, not overridden.

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 bus request, level
- m1_req  in  1  master 1 bus request, level
- m0_grant  out  1  master 0 owns bus; drives mux select low
- m1_grant  out  1  master 1 owns bus; drives mux select high
- bus_busy  out  1  m0_grant | m1_grant
- preempt  out  1  one-cycle flag, high in the first grant cycle after a forced (MAX_HOLD) handoff
- hold_cnt  out  CW  cycles already granted to current owner, minus 1; 0 in IDLE

## Operation
- State register, encoded: IDLE, GNT0, GNT1. m0_grant = (state==GNT0), m1_grant = (state==GNT1).
- `last` register: the last master granted. Reset value 1, so m0 wins the first tie.
- IDLE:
  - both req: go to GNT1 if last==0, else GNT0.
  - one req: go to that master's grant state.
  - none: stay in IDLE.
- GNTx (x = owner, y = other):
  - !mx_req & my_req: go to GNTy (direct handoff, no idle cycle).
  - !mx_req & !my_req: go to IDLE.
  - mx_req & my_req & hold_cnt==MAX_HOLD-1: go to GNTy and set preempt for the next cycle.
  - otherwise: stay in GNTx.
- hold_cnt:
  - Loads 0 on every entry into a grant state, and in IDLE.
  - Otherwise increments each cycle in the grant state.
  - Saturates at MAX_HOLD-1; an uncontested owner keeps the grant indefinitely with hold_cnt held at MAX_HOLD-1.
- `last` updates to x on every entry into GNTx.
- preempt is registered. It is high only in the cycle the forced new grant first appears; it is 0 for voluntary handoffs.
- Requests are sampled, not qualified: a master dropping req for one cycle releases the bus.

## Timing
- Reset values (cycle after reset sampled high): state IDLE, both grants 0, bus_busy 0, preempt 0, hold_cnt 0, last 1.
- Reset mid-grant: grant drops on the next edge, with no handoff to the other master.
- Grant latency: req sampled high at edge N gives the grant visible after edge N (Moore output); 1 cycle from IDLE.
- Release latency: req low at edge N drops the grant after edge N.
- Under continuous contention the owner holds exactly MAX_HOLD cycles, then the other master gets MAX_HOLD cycles. The pattern alternates with no gap cycles.
- Invariant: grants are never both 1, checked every cycle.
- Simultaneous release by the owner and a new request from the other master: handoff occurs with no idle cycle.

## Test plan
- Reset, then m0_req=m1_req=1 on the same edge: m0_grant=1 the next cycle, preempt=0. All outputs are 0 during reset.
- m0_req held high alone for 20 cycles: m0_grant stays 1, and hold_cnt saturates at 7 (MAX_HOLD=8).
- m0 granted, then m1_req=1 while m0_req stays high: m0_grant lasts exactly 8 cycles total, then m1_grant=1 with preempt=1 for 1 cycle. The pattern alternates with an 8-cycle period.
- m0 granted, then at one edge m0_req=0 and m1_req=1: the next cycle gives m1_grant=1, m0_grant=0, preempt=0, hold_cnt=0.
- m1 is the last granted and both go idle, then both request together: m0_grant=1 (round-robin tie-break).
- reset asserted for 1 cycle mid-contention with hold_cnt=5: the next cycle gives both grants 0, then the cycle after gives m0_grant=1 (last reset to 1). Random request stress must show no cycle with both grants high.

Source files
------------

// File: rtl/bus_arbit_rr.sv
// rtl/bus_arbit_rr.sv - two-master round-robin bus arbiter with bounded hold time
module bus_arbit_rr #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = $clog2(MAX_HOLD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m1_req,
    output logic          m0_grant,
    output logic          m1_grant,
    output logic          bus_busy,
    output logic          preempt,
    output logic [CW-1:0] hold_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Saturation value of the hold counter; reaching it under contention forces a handoff.
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    state_t        state;
    state_t        state_nxt;
    logic          last;
    logic          last_nxt;
    logic          preempt_q;
    logic          preempt_nxt;
    logic [CW-1:0] hold_q;
    logic [CW-1:0] hold_nxt;
    logic          hold_sat;

    assign hold_sat = (hold_q == HOLD_LAST);

    // State, last-owner, hold counter and preempt flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            hold_q    <= hold_nxt;
            preempt_q <= preempt_nxt;
        end
    end

    // Next-state selection: tie-break on the last owner, voluntary and forced handoffs.
    always_comb begin
        state_nxt   = state;
        preempt_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_nxt = last ? GNT0 : GNT1;
                end else if (m0_req) begin
                    state_nxt = GNT0;
                end else if (m1_req) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_req && m1_req) begin
                    state_nxt = GNT1;
                end else if (!m0_req && !m1_req) begin
                    state_nxt = IDLE;
                end else if (m0_req && m1_req && hold_sat) begin
                    state_nxt   = GNT1;
                    preempt_nxt = 1'b1;
                end
            end
            GNT1: begin
                if (!m1_req && m0_req) begin
                    state_nxt = GNT0;
                end else if (!m1_req && !m0_req) begin
                    state_nxt = IDLE;
                end else if (m1_req && m0_req && hold_sat) begin
                    state_nxt   = GNT0;
                    preempt_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Hold counter restarts on every new grant, counts while the owner stays, saturates.
    always_comb begin
        hold_nxt = hold_q;
        if (state_nxt == IDLE || state_nxt != state) begin
            hold_nxt = '0;
        end else if (!hold_sat) begin
            hold_nxt = hold_q + 1'b1;
        end
    end

    // Last owner follows each entry into a grant state.
    always_comb begin
        last_nxt = last;
        if (state_nxt == GNT0 && state != GNT0) begin
            last_nxt = 1'b0;
        end else if (state_nxt == GNT1 && state != GNT1) begin
            last_nxt = 1'b1;
        end
    end

    assign m0_grant = (state == GNT0);
    assign m1_grant = (state == GNT1);
    assign bus_busy = m0_grant | m1_grant;
    assign preempt  = preempt_q;
    assign hold_cnt = hold_q;

endmodule

// File: tb/tb_bus_arbit_rr.sv
// tb/tb_bus_arbit_rr.sv - directed self-checking bench for bus_arbit_rr
module tb_bus_arbit_rr;

    localparam int MAX_HOLD = 8;
    localparam int CW       = $clog2(MAX_HOLD);

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req;
    logic          m1_req;
    logic          m0_grant;
    logic          m1_grant;
    logic          bus_busy;
    logic          preempt;
    logic [CW-1:0] hold_cnt;

    int checks = 0;
    int errors = 0;

    bus_arbit_rr #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m1_req   (m1_req),
        .m0_grant (m0_grant),
        .m1_grant (m1_grant),
        .bus_busy (bus_busy),
        .preempt  (preempt),
        .hold_cnt (hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int g0, input int g1,
                              input int pre, input int hc);
        check({tag, ".m0_grant"}, int'(m0_grant), g0);
        check({tag, ".m1_grant"}, int'(m1_grant), g1);
        check({tag, ".bus_busy"}, int'(bus_busy), g0 | g1);
        check({tag, ".preempt"},  int'(preempt),  pre);
        check({tag, ".hold_cnt"}, int'(hold_cnt), hc);
    endtask

    // Grants must never overlap, in any cycle.
    always @(negedge clk) begin
        if (reset === 1'b0) check("mutex", int'(m0_grant & m1_grant), 0);
    end

    initial begin
        reset  = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        tick();
        expect_out("reset_idle", 0, 0, 0, 0);
        m0_req = 1'b1;
        m1_req = 1'b1;
        tick();
        expect_out("reset_with_req", 0, 0, 0, 0);

        // First tie after reset goes to m0, then continuous contention alternates every 8.
        reset = 1'b0;
        tick();
        expect_out("first_tie", 1, 0, 0, 0);
        for (int i = 1; i < MAX_HOLD; i++) begin
            tick();
            expect_out("cont_m0", 1, 0, 0, i);
        end
        tick();
        expect_out("preempt_to_m1", 0, 1, 1, 0);
        for (int i = 1; i < MAX_HOLD; i++) begin
            tick();
            expect_out("cont_m1", 0, 1, 0, i);
        end
        tick();
        expect_out("preempt_to_m0", 1, 0, 1, 0);

        // Owner releases while the other requests: direct voluntary handoff.
        m0_req = 1'b0;
        m1_req = 1'b1;
        tick();
        expect_out("vol_handoff", 0, 1, 0, 0);

        // Both idle with last=1, then a tie goes to m0.
        m1_req = 1'b0;
        tick();
        expect_out("release_idle", 0, 0, 0, 0);
        m0_req = 1'b1;
        m1_req = 1'b1;
        tick();
        expect_out("rr_tie_m0", 1, 0, 0, 0);

        // Uncontested owner keeps the bus; counter saturates.
        m1_req = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            expect_out("solo_m0", 1, 0, 0, (i < MAX_HOLD - 1) ? i : MAX_HOLD - 1);
        end
        // A saturated owner loses the bus at the very next contested edge.
        m1_req = 1'b1;
        tick();
        expect_out("sat_preempt", 0, 1, 1, 0);

        // With last=0, an idle tie goes to m1.
        m1_req = 1'b0;
        tick();
        expect_out("vol_to_m0", 1, 0, 0, 0);
        m0_req = 1'b0;
        tick();
        expect_out("idle_again", 0, 0, 0, 0);
        m0_req = 1'b1;
        m1_req = 1'b1;
        tick();
        expect_out("rr_tie_m1", 0, 1, 0, 0);

        // Reset mid-contention while m0 owns the bus with hold_cnt=5.
        for (int i = 1; i < MAX_HOLD; i++) tick();
        tick();
        expect_out("pre_reset_gnt0", 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) tick();
        expect_out("hold5", 1, 0, 0, 5);
        reset = 1'b1;
        tick();
        expect_out("mid_reset", 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        expect_out("after_reset_tie", 1, 0, 0, 0);

        // Random request stress; the mutex monitor watches every cycle.
        for (int i = 0; i < 400; i++) begin
            m0_req = 1'($urandom_range(0, 1));
            m1_req = 1'($urandom_range(0, 1));
            tick();
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        tick();
        expect_out("final_idle", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
